// File: rtl/bus_reg_bank.sv
// Small register bank on a shared bus: save, increment, clear, and a one-cycle-latency
// tri-state readback that returns the post-update register value.
module bus_reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   save_en,
    input  logic [AW-1:0]          save_addr,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   inc_en,
    input  logic [AW-1:0]          inc_addr,
    input  logic                   clr_en,
    input  logic                   load_en,
    input  logic [AW-1:0]          load_addr,
    output wire logic [WIDTH-1:0]  data_out,
    output logic                   data_out_valid,
    output logic [DEPTH*WIDTH-1:0] data_out_always,
    output logic                   carry,
    output logic                   addr_err
);

    logic [WIDTH-1:0] regs_r     [DEPTH];
    logic [WIDTH-1:0] regs_nxt_s [DEPTH];
    logic [DEPTH-1:0] save_hit_s;
    logic [DEPTH-1:0] inc_hit_s;
    logic [DEPTH-1:0] load_hit_s;
    logic [WIDTH-1:0] load_val_s;
    logic             wrap_s;
    logic             err_s;
    logic [WIDTH-1:0] dout_r;
    logic             valid_r;
    logic             carry_r;
    logic             addr_err_r;

    // Address decode; an enabled access that hits no register is out of range.
    always_comb begin
        save_hit_s = {DEPTH{1'b0}};
        inc_hit_s  = {DEPTH{1'b0}};
        load_hit_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            save_hit_s[i] = save_en && (save_addr == AW'(i));
            inc_hit_s[i]  = inc_en  && (inc_addr  == AW'(i));
            load_hit_s[i] = load_en && (load_addr == AW'(i));
        end
        err_s = (save_en && !(|save_hit_s)) ||
                (inc_en  && !(|inc_hit_s))  ||
                (load_en && !(|load_hit_s));
    end

    // Next register values (clear > save > increment) and the write-through load value.
    always_comb begin
        wrap_s     = 1'b0;
        load_val_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_en) begin
                regs_nxt_s[i] = {WIDTH{1'b0}};
            end else if (save_hit_s[i]) begin
                regs_nxt_s[i] = data_in;
            end else if (inc_hit_s[i]) begin
                regs_nxt_s[i] = regs_r[i] + WIDTH'(1'b1);
            end else begin
                regs_nxt_s[i] = regs_r[i];
            end
            // Carry only when the increment actually lands on the register.
            wrap_s = wrap_s | (!clr_en && inc_hit_s[i] && !save_hit_s[i] &&
                               (regs_r[i] == {WIDTH{1'b1}}));
            load_val_s = load_val_s | (load_hit_s[i] ? regs_nxt_s[i] : {WIDTH{1'b0}});
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= regs_nxt_s[i];
            end
        end
    end

    // Registered bus readback and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r     <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            carry_r    <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            dout_r     <= load_en ? load_val_s : {WIDTH{1'b0}};
            valid_r    <= load_en;
            carry_r    <= wrap_s;
            addr_err_r <= err_s;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign data_out_always[g*WIDTH +: WIDTH] = regs_r[g];
    end

    assign data_out       = valid_r ? dout_r : {WIDTH{1'bz}};
    assign data_out_valid = valid_r;
    assign carry          = carry_r;
    assign addr_err       = addr_err_r;

endmodule
